// File: rtl/counter_scoreboard_pkg.sv
// Shared definitions for the multi-mode counter: data width and mode encodings,
// reused by the DUT, the driver and the checker.
package counter_pkg;

  parameter int unsigned WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_UP3  = 2'b00,
    MODE_DN1  = 2'b01,
    MODE_UP1  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/counter_scoreboard_if.sv
// Stimulus/response bundle of the multi-mode counter; the driver side is master,
// the reference model side is slave.
interface counter_scoreboard_if #(
  parameter int unsigned WIDTH = counter_pkg::WIDTH
);

  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic             load;
  logic             rco;
  logic [WIDTH-1:0] Q;

  modport master (
    output enable, mode, D,
    input  load, rco, Q
  );

  modport slave (
    input  enable, mode, D,
    output load, rco, Q
  );

endinterface

// File: rtl/counter_scoreboard.sv
// Cycle-accurate golden model of the 4-bit multi-mode counter: produces the
// expected registered Q, rco and load from the same stimulus the DUT sees.
module counter_scoreboard
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = counter_pkg::WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  counter_scoreboard_if.slave bus
);

  localparam logic [WIDTH:0] THREE = (WIDTH+1)'(3);
  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             load_q, load_d;
  logic [WIDTH:0]   sum;

  // The extra top bit of sum carries the wrap: carry for the up modes, borrow for down.
  always_comb begin
    q_d    = q_q;
    rco_d  = 1'b0;
    load_d = 1'b0;
    sum    = '0;
    if (bus.enable) begin
      case (bus.mode)
        MODE_UP3: begin
          sum   = {1'b0, q_q} + THREE;
          q_d   = sum[WIDTH-1:0];
          rco_d = sum[WIDTH];
        end
        MODE_DN1: begin
          sum   = {1'b0, q_q} - ONE;
          q_d   = sum[WIDTH-1:0];
          rco_d = sum[WIDTH];
        end
        MODE_UP1: begin
          sum   = {1'b0, q_q} + ONE;
          q_d   = sum[WIDTH-1:0];
          rco_d = sum[WIDTH];
        end
        MODE_LOAD: begin
          q_d    = bus.D;
          load_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.rco  = rco_q;
  assign bus.load = load_q;

endmodule

// File: tb/tb_counter_scoreboard.sv
// Directed bench for the counter reference model: a vector table of expected
// Q/rco/load per edge, plus short hand-written corner-case sequences.
module tb_counter_scoreboard;
  import counter_pkg::*;

  localparam int unsigned W = counter_pkg::WIDTH;

  typedef struct {
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
    logic         exp_rco;
    logic         exp_load;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  counter_scoreboard_if #(.WIDTH(W)) bus ();

  counter_scoreboard #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic rst, input logic en, input logic [1:0] mode,
                              input logic [W-1:0] d, input logic [W-1:0] q,
                              input logic rco, input logic ld);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.d = d;
    v.exp_q = q; v.exp_rco = rco; v.exp_load = ld;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic en, input logic [1:0] mode,
                      input logic [W-1:0] d, input logic [W-1:0] eq,
                      input logic er, input logic el, input string name);
    @(negedge clk);
    reset      = rst;
    bus.enable = en;
    bus.mode   = mode;
    bus.D      = d;
    @(posedge clk);
    #1;
    total++;
    if (bus.Q !== eq) begin
      bad++;
      $display("FAIL %s Q: got %0d expected %0d", name, bus.Q, eq);
    end
    total++;
    if (bus.rco !== er) begin
      bad++;
      $display("FAIL %s rco: got %b expected %b", name, bus.rco, er);
    end
    total++;
    if (bus.load !== el) begin
      bad++;
      $display("FAIL %s load: got %b expected %b", name, bus.load, el);
    end
  endtask

  initial begin
    reset      = 1'b0;
    bus.enable = 1'b1;
    bus.mode   = MODE_UP3;
    bus.D      = '0;

    // reset held for two edges
    add(0, 1, MODE_UP3, 0, 0, 0, 0);
    add(0, 1, MODE_UP3, 0, 0, 0, 0);
    // up by 3 from 0
    add(1, 1, MODE_UP3, 0, 3, 0, 0);
    add(1, 1, MODE_UP3, 0, 6, 0, 0);
    add(1, 1, MODE_UP3, 0, 9, 0, 0);
    add(1, 1, MODE_UP3, 0, 12, 0, 0);
    add(1, 1, MODE_UP3, 0, 15, 0, 0);
    add(1, 1, MODE_UP3, 0, 2, 1, 0);
    // back to 0, then down by 1 for 17 edges
    add(0, 1, MODE_DN1, 0, 0, 0, 0);
    add(1, 1, MODE_DN1, 0, 15, 1, 0);
    for (int i = 14; i >= 0; i--) add(1, 1, MODE_DN1, 0, W'(i), 0, 0);
    add(1, 1, MODE_DN1, 0, 15, 1, 0);
    // load 13, then up by 1
    add(1, 1, MODE_LOAD, 13, 13, 0, 1);
    add(1, 1, MODE_UP1, 0, 14, 0, 0);
    add(1, 1, MODE_UP1, 0, 15, 0, 0);
    add(1, 1, MODE_UP1, 0, 0, 1, 0);
    add(1, 1, MODE_UP1, 0, 1, 0, 0);
    // back-to-back loads, then switch to count
    add(1, 1, MODE_LOAD, 9, 9, 0, 1);
    add(1, 1, MODE_LOAD, 4, 4, 0, 1);
    add(1, 1, MODE_UP1, 0, 5, 0, 0);
    // hold at 7 in any mode, then reset mid-count
    add(1, 1, MODE_LOAD, 7, 7, 0, 1);
    add(1, 0, MODE_UP3, 0, 7, 0, 0);
    add(1, 0, MODE_DN1, 0, 7, 0, 0);
    add(1, 0, MODE_LOAD, 3, 7, 0, 0);
    add(1, 1, MODE_UP3, 0, 10, 0, 0);
    add(0, 1, MODE_UP3, 0, 0, 0, 0);
    add(1, 1, MODE_UP1, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d,
           vecs[i].exp_q, vecs[i].exp_rco, vecs[i].exp_load, $sformatf("vec%0d", i));
    end

    // enable toggling resumes from the held value
    step(0, 1, MODE_UP1, 0, 0, 0, 0, "tog_rst");
    step(1, 1, MODE_UP1, 0, 1, 0, 0, "tog_run1");
    step(1, 0, MODE_UP1, 0, 1, 0, 0, "tog_hold1");
    step(1, 1, MODE_UP1, 0, 2, 0, 0, "tog_run2");
    step(1, 0, MODE_LOAD, 15, 2, 0, 0, "tog_hold_load");
    step(1, 1, MODE_DN1, 0, 1, 0, 0, "tog_down");

    // up-by-3 boundary: 12 -> 15 no carry, 13 -> 0 carry
    step(1, 1, MODE_LOAD, 12, 12, 0, 1, "b_load12");
    step(1, 1, MODE_UP3, 0, 15, 0, 0, "b_12p3");
    step(1, 1, MODE_LOAD, 13, 13, 0, 1, "b_load13");
    step(1, 1, MODE_UP3, 0, 0, 1, 0, "b_13p3");
    step(1, 1, MODE_UP3, 0, 3, 0, 0, "b_after_wrap");
    // reset wins over a load request
    step(0, 1, MODE_LOAD, 9, 0, 0, 0, "b_rst_over_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
